pd_gen_sched: RTL

PD_GEN_SCHED -- requirements
Module: pd_gen_sched

---
 rtl/pd_gen_sched.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/pd_gen_sched.sv
// -----------------------------------------------------------------------------
// pd_gen_sched
//
// Rate scheduler in front of the PCIe packet identifier. It passes 512-bit
// beats from the pd register downstream with one cycle of latency, selects the
// 8b10b (Gen1/2) or 128b130b (Gen3-5) datapath, and produces a per-byte valid
// mask sized for the active generation. A change of requested generation
// while streaming drains the pipe for DRAIN_CYCLES idle cycles, then switches
// rate in a single SWITCH cycle. Beats arriving during a switch are dropped.
//
// Parameters
//   DRAIN_CYCLES  idle cycles inserted before a rate switch (1..15)
//   IDLE_TIMEOUT  consecutive beat-free RUN cycles before returning to IDLE
//                 (1..255)
//
// Configuration
//   PD_GEN_SCHED_DROPCNT_EN  when defined, drop_cnt counts dropped beats
//                            (saturating at 255); when undefined, drop_cnt is
//                            tied to zero and no counter is built.
//
// Ports
//   clk         in   1   clock, all state on rising edge
//   rst         in   1   asynchronous active-high reset
//   gen         in   3   requested PCIe generation, legal 1..5
//   hld_pd_gen  in   1   a beat is present in the pd register this cycle
//   sel         out  1   datapath select: 0 = 8b10b, 1 = 128b130b
//   valid       out 64   per-byte valid mask of the current beat
//   w           out  1   beat write strobe to the packet identifier
//   busy        out  1   scheduler is not IDLE
//   err         out  1   sticky illegal-generation flag
//   drop_cnt    out  8   beats dropped during rate switches
// -----------------------------------------------------------------------------
module pd_gen_sched #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned IDLE_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  gen,
    input  logic        hld_pd_gen,
    output logic        sel,
    output logic [63:0] valid,
    output logic        w,
    output logic        busy,
    output logic        err,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_SWITCH = 2'd3
    } state_e;

    // Only generations 1..5 exist; 0, 6 and 7 are treated as fatal input.
    function automatic logic gen_is_legal(input logic [2:0] g);
        return (g >= 3'd1) && (g <= 3'd5);
    endfunction

    // Gen3 and above use the 128b130b datapath.
    function automatic logic gen_to_sel(input logic [2:0] g);
        return (g >= 3'd3);
    endfunction

    // Bytes carried per 512-bit beat at each generation.
    function automatic logic [63:0] gen_to_mask(input logic [2:0] g);
        logic [63:0] m;
        case (g)
            3'd1:    m = 64'h0000_0000_0000_00FF;
            3'd2:    m = 64'h0000_0000_0000_FFFF;
            3'd3:    m = 64'h0000_0000_FFFF_FFFF;
            3'd4,
            3'd5:    m = 64'hFFFF_FFFF_FFFF_FFFF;
            default: m = 64'h0;
        endcase
        return m;
    endfunction

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);
    localparam logic [8:0] TMO_LIMIT  = 9'(IDLE_TIMEOUT);

    state_e      state_q,     state_d;
    logic [2:0]  cur_gen_q,   cur_gen_d;
    logic [2:0]  tgt_gen_q,   tgt_gen_d;   // generation being drained towards
    logic        sel_q,       sel_d;
    logic        w_q,         w_d;
    logic [63:0] valid_q,     valid_d;
    logic        err_q,       err_d;
    logic [3:0]  drain_cnt_q, drain_cnt_d;
    logic [7:0]  tmo_cnt_q,   tmo_cnt_d;

    logic        gen_legal;
    logic [8:0]  tmo_next;

    assign gen_legal = gen_is_legal(gen);
    assign tmo_next  = {1'b0, tmo_cnt_q} + 9'd1;

    // NOTE: every signal driven here gets a default before the case so that no
    // path leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        state_d     = state_q;
        cur_gen_d   = cur_gen_q;
        tgt_gen_d   = tgt_gen_q;
        sel_d       = sel_q;
        w_d         = 1'b0;
        valid_d     = 64'h0;
        err_d       = err_q;
        drain_cnt_d = drain_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;

        if (!gen_legal) begin
            // Illegal generation overrides every transition and kills the beat.
            err_d       = 1'b1;
            state_d     = ST_IDLE;
            drain_cnt_d = 4'd0;
            tmo_cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hld_pd_gen) begin
                        cur_gen_d = gen;
                        tgt_gen_d = gen;
                        sel_d     = gen_to_sel(gen);
                        w_d       = 1'b1;
                        valid_d   = gen_to_mask(gen);
                        tmo_cnt_d = 8'd0;
                        state_d   = ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (gen != cur_gen_q) begin
                        // Rate change: any beat in this cycle is dropped.
                        tgt_gen_d   = gen;
                        drain_cnt_d = DRAIN_LOAD;
                        tmo_cnt_d   = 8'd0;
                        state_d     = ST_DRAIN;
                    end else if (hld_pd_gen) begin
                        w_d       = 1'b1;
                        valid_d   = gen_to_mask(cur_gen_q);
                        tmo_cnt_d = 8'd0;
                    end else if (tmo_next >= TMO_LIMIT) begin
                        tmo_cnt_d = 8'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        tmo_cnt_d = tmo_next[7:0];
                    end
                end

                ST_DRAIN: begin
                    if (gen != tgt_gen_q) begin
                        // Target moved again: restart the full drain window.
                        tgt_gen_d   = gen;
                        drain_cnt_d = DRAIN_LOAD;
                    end else if (drain_cnt_q <= 4'd1) begin
                        drain_cnt_d = 4'd0;
                        state_d     = ST_SWITCH;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 4'd1;
                    end
                end

                ST_SWITCH: begin
                    // The only place besides IDLE->RUN where sel may move.
                    cur_gen_d = gen;
                    tgt_gen_d = gen;
                    sel_d     = gen_to_sel(gen);
                    tmo_cnt_d = 8'd0;
                    state_d   = ST_RUN;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_gen_q   <= 3'd1;
            tgt_gen_q   <= 3'd1;
            sel_q       <= 1'b0;
            w_q         <= 1'b0;
            valid_q     <= 64'h0;
            err_q       <= 1'b0;
            drain_cnt_q <= 4'd0;
            tmo_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            cur_gen_q   <= cur_gen_d;
            tgt_gen_q   <= tgt_gen_d;
            sel_q       <= sel_d;
            w_q         <= w_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            drain_cnt_q <= drain_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign sel   = sel_q;
    assign w     = w_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = (state_q != ST_IDLE);

`ifdef PD_GEN_SCHED_DROPCNT_EN
    logic       drop_evt;
    logic [7:0] drop_cnt_q;

    // A beat is lost whenever the scheduler is mid-switch, or arrives in the
    // very cycle RUN detects a legal rate change.
    assign drop_evt = hld_pd_gen &&
                      ((state_q == ST_DRAIN) || (state_q == ST_SWITCH) ||
                       ((state_q == ST_RUN) && gen_legal && (gen != cur_gen_q)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else if (drop_evt && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule
